ysyx_25040109_ifu_prefetch: RTL

YSYX_25040109_IFU_PREFETCH -- requirements
Module: ysyx_25040109_ifu_prefetch

---
 rtl/ysyx_25040109_pkg.sv | 19 +
 rtl/ysyx_25040109_sync_fifo.sv | 67 ++++++
 rtl/ysyx_25040109_ifu_prefetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040109_pkg.sv
// Shared constants and encodings for the ysyx_25040109 fetch front end.
// Faulted queue entries carry the NOP word and one of the fault codes below.
package ysyx_25040109_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE   = 2'b00,
    FAULT_WINDOW = 2'b01,
    FAULT_MISAL  = 2'b10,
    FAULT_BUS    = 2'b11
  } fault_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/ysyx_25040109_sync_fifo.sv
// Single-clock FIFO with flush; push while full is accepted only with a pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_25040109_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/ysyx_25040109_ifu_prefetch.sv
// Instruction prefetch unit: credit-limited fetch, in-order response queue,
// fault entries, and redirect flush with drop tracking of stale responses.
module ysyx_25040109_ifu_prefetch
  import ysyx_25040109_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [1:0]      inst_fault
);

  localparam int QW = XLEN + 34;
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 2;

  logic            live_q;
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            hold_q, hold_d;
  logic            hold_drop_q, hold_drop_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;

  logic            q_push, q_pop, q_full, q_empty;
  logic [QW-1:0]   q_din, q_dout;
  logic [CW-1:0]   q_count;
  logic            f_push, f_pop, f_full, f_empty;
  logic [XLEN-1:0] f_dout;
  logic [CW-1:0]   f_count;

  logic            misal, in_win, credit;
  logic [SW-1:0]   used;
  logic            new_req, req_fire, rsp_fire;
  logic            fault_push, owed;
  fault_e          fcode;

  assign misal  = (pc_q[1:0] != 2'b00);
  assign in_win = (pc_q >= MEM_BASE) &&
                  ((pc_q - MEM_BASE) < MEM_SIZE);
  assign fcode  = misal ? FAULT_MISAL : FAULT_WINDOW;

  // Dropped responses still occupy a credit until they come back.
  assign used   = SW'(f_count) + SW'(drop_q) + SW'(q_count);
  assign credit = (used < SW'(DEPTH));

  assign new_req = live_q && (state_q == ST_RUN) && !misal &&
                   in_win && credit && !hold_q && !f_full;

  assign imem_req_valid = hold_q || new_req;
  assign imem_req_addr  = hold_q ? hold_addr_q : pc_q;
  assign imem_rsp_ready = rst;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && imem_rsp_ready;
  assign owed     = imem_req_valid && !(hold_q && hold_drop_q);

  assign fault_push = live_q && (state_q == ST_RUN) &&
                      (misal || !in_win) && f_empty &&
                      credit && !q_full;

  assign inst_valid = !q_empty;
  assign inst_pc    = q_empty ? '0 : q_dout[QW-1:34];
  assign inst_data  = q_empty ? NOP : q_dout[33:2];
  assign inst_fault = q_empty ? 2'b00 : q_dout[1:0];
  assign q_pop      = inst_valid && inst_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    hold_d      = imem_req_valid && !imem_req_ready;
    hold_addr_d = imem_req_addr;
    hold_drop_d = hold_q && hold_drop_q;
    f_push      = 1'b0;
    f_pop       = 1'b0;
    q_push      = 1'b0;
    q_din       = {pc_q, NOP, FAULT_NONE};
    if (redirect_valid) begin
      state_d     = ST_RUN;
      pc_d        = redirect_pc;
      drop_d      = drop_q + f_count + CW'(owed)
                  - CW'(rsp_fire);
      hold_drop_d = 1'b1;
    end else begin
      if (req_fire && !(hold_q && hold_drop_q)) begin
        f_push = 1'b1;
        pc_d   = imem_req_addr + XLEN'(4);
      end
      if (rsp_fire) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (!f_empty) begin
          f_pop = 1'b1;
          if (state_q == ST_RUN) begin
            q_push = 1'b1;
            if (imem_rsp_err) begin
              q_din   = {f_dout, NOP, FAULT_BUS};
              state_d = ST_HALT;
            end else begin
              q_din = {f_dout, imem_rsp_data, FAULT_NONE};
            end
          end
        end
      end
      if (fault_push) begin
        q_push  = 1'b1;
        q_din   = {pc_q, NOP, fcode};
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q      <= 1'b0;
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      drop_q      <= '0;
      hold_q      <= 1'b0;
      hold_drop_q <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      live_q      <= 1'b1;
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      hold_q      <= hold_d;
      hold_drop_q <= hold_drop_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  ysyx_25040109_sync_fifo #(
    .WIDTH(QW),
    .DEPTH(DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_din),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .pop_data  (q_dout),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  ysyx_25040109_sync_fifo #(
    .WIDTH(XLEN),
    .DEPTH(DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (f_push),
    .push_data (imem_req_addr),
    .pop       (f_pop),
    .flush     (redirect_valid),
    .pop_data  (f_dout),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

endmodule
